cordic_hyper_vec: RTL and testbench

- Parametrised, multi-mode successor to the fixed-function pipelined arctanh CORDIC.
- Computes atanh(x) or ln(x) with a hyperbolic vectoring CORDIC.
- Adds output backpressure, domain-error flagging and a user sideband carried alongside each sample.
- Sits in the fixed-point math library and feeds downstream DSP blocks through a valid/ready stream.

---
 rtl/cordic_hyper_vec.sv | 161 ++++++++++++++++
 tb/tb_cordic_hyper_vec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_hyper_vec.sv
// Pipelined hyperbolic vectoring CORDIC: atanh(x) (mode 0) or ln(x) (mode 1)
// with valid/ready backpressure, domain-error flag and a user sideband.
module cordic_hyper_vec #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 16,
    parameter int PIPELINE = 16,
    parameter int USER_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pre_vaild,
    output logic                     pre_ready,
    input  logic                     mode,
    input  logic signed [WIDTH-1:0]  iData,
    input  logic [USER_W-1:0]        iUser,
    output logic                     post_vaild,
    input  logic                     post_ready,
    output logic signed [WIDTH-1:0]  oData,
    output logic [USER_W-1:0]        oUser,
    output logic                     oErr
);

    localparam int N     = PIPELINE + ((PIPELINE >= 4) ? 1 : 0) + ((PIPELINE >= 13) ? 1 : 0);
    // Guard bits keep the shift truncation error well below one output LSB.
    localparam int GUARD = 6;
    localparam int IF    = FRAC + GUARD;
    localparam int IW    = WIDTH + 2 + GUARD;

    localparam logic signed [IW-1:0]    ONE       = IW'(64'd1 << IF);
    localparam logic signed [IW:0]      HALF      = (IW+1)'(64'd1 << (GUARD - 1));
    localparam logic signed [WIDTH-1:0] LIM_ATANH = WIDTH'((64'd8 * (64'd1 << FRAC) + 64'd5) / 64'd10);
    localparam logic signed [WIDTH-1:0] LIM_LN_LO = WIDTH'((64'd11 * (64'd1 << FRAC) + 64'd50) / 64'd100);
    localparam logic signed [WIDTH-1:0] LIM_LN_HI = WIDTH'(64'd9 << FRAC);

    // Iterations 4 and 13 are each executed twice to guarantee convergence.
    function automatic int iter_of(input int k);
        int i;
        i = k + 1;
        if (PIPELINE >= 4 && k >= 4)
            i = k;
        if (PIPELINE >= 13 && k >= 14)
            i = k - 1;
        return i;
    endfunction

    function automatic logic [63:0] atanh_q32(input int i);
        case (i)
            1:       return 64'd2359251925;
            2:       return 64'd1096989674;
            3:       return 64'd539693625;
            4:       return 64'd268785803;
            5:       return 64'd134261444;
            6:       return 64'd67114326;
            7:       return 64'd33555115;
            8:       return 64'd16777301;
            9:       return 64'd8388619;
            10:      return 64'd4194305;
            11:      return 64'd2097152;
            12:      return 64'd1048576;
            13:      return 64'd524288;
            14:      return 64'd262144;
            15:      return 64'd131072;
            16:      return 64'd65536;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic signed [IW-1:0] t_at(input int k);
        logic [63:0] t32;
        t32 = atanh_q32(iter_of(k));
        t32 = (t32 + (64'd1 << (31 - IF))) >> (32 - IF);
        return t32[IW-1:0];
    endfunction

    logic                    stall;
    logic [N:0]              vld_q;
    logic [N:0]              mode_q;
    logic [N:0]              err_q;
    logic [USER_W-1:0]       user_q [0:N];
    logic signed [IW-1:0]    x_q    [0:N-1];
    logic signed [IW-1:0]    y_q    [0:N-1];
    logic signed [IW-1:0]    z_q    [0:N];
    logic signed [IW-1:0]    d_ext;
    logic                    err_in;
    logic signed [IW:0]      z_sel;
    logic signed [IW:0]      z_rnd;
    logic                    ovf;
    logic signed [WIDTH-1:0] data_sat;

    assign stall     = post_vaild & ~post_ready;
    assign pre_ready = ~stall;
    assign d_ext     = IW'(iData) <<< GUARD;

    always_comb begin
        err_in = 1'b0;
        if (mode)
            err_in = (iData <= LIM_LN_LO) || (iData >= LIM_LN_HI);
        else
            err_in = (iData >= LIM_ATANH) || (iData <= -LIM_ATANH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_q <= '0;
        else if (!stall)
            vld_q <= {vld_q[N-1:0], pre_vaild};
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            mode_q[0] <= mode;
            err_q[0]  <= err_in;
            user_q[0] <= iUser;
            x_q[0]    <= mode ? d_ext + ONE : ONE;
            y_q[0]    <= mode ? d_ext - ONE : d_ext;
            z_q[0]    <= '0;
            for (int k = 0; k < N - 1; k++) begin
                if (!y_q[k][IW-1]) begin
                    x_q[k+1] <= x_q[k] - (y_q[k] >>> iter_of(k));
                    y_q[k+1] <= y_q[k] - (x_q[k] >>> iter_of(k));
                end else begin
                    x_q[k+1] <= x_q[k] + (y_q[k] >>> iter_of(k));
                    y_q[k+1] <= y_q[k] + (x_q[k] >>> iter_of(k));
                end
            end
            for (int k = 0; k < N; k++) begin
                mode_q[k+1] <= mode_q[k];
                err_q[k+1]  <= err_q[k];
                user_q[k+1] <= user_q[k];
                z_q[k+1]    <= y_q[k][IW-1] ? z_q[k] - t_at(k) : z_q[k] + t_at(k);
            end
        end
    end

    // ln(x) = 2*atanh((x-1)/(x+1)); double before rounding away the guard bits.
    always_comb begin
        z_sel    = mode_q[N] ? {z_q[N], 1'b0} : {z_q[N][IW-1], z_q[N]};
        z_rnd    = (z_sel + HALF) >>> GUARD;
        ovf      = !((&z_rnd[IW:WIDTH-1]) || !(|z_rnd[IW:WIDTH-1]));
        data_sat = z_rnd[WIDTH-1:0];
        if (ovf)
            data_sat = z_rnd[IW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vaild <= 1'b0;
            oData      <= '0;
            oUser      <= '0;
            oErr       <= 1'b0;
        end else if (!stall) begin
            post_vaild <= vld_q[N];
            if (vld_q[N]) begin
                oData <= err_q[N] ? '0 : data_sat;
                oErr  <= err_q[N];
                oUser <= user_q[N];
            end
        end
    end

endmodule

// File: tb/tb_cordic_hyper_vec.sv
// Randomised and directed bench for cordic_hyper_vec, checked against an
// exact real-arithmetic atanh/ln model with an in-order expectation queue.
module tb_cordic_hyper_vec;

    localparam int WIDTH    = 32;
    localparam int FRAC     = 16;
    localparam int PIPELINE = 16;
    localparam int USER_W   = 8;
    // 16 iterations + 2 repeated ones + preprocessing stage + output register
    localparam int LAT      = 20;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pre_vaild;
    logic                    pre_ready;
    logic                    mode;
    logic signed [WIDTH-1:0] iData;
    logic [USER_W-1:0]       iUser;
    logic                    post_vaild;
    logic                    post_ready;
    logic signed [WIDTH-1:0] oData;
    logic [USER_W-1:0]       oUser;
    logic                    oErr;

    cordic_hyper_vec #(
        .WIDTH(WIDTH), .FRAC(FRAC), .PIPELINE(PIPELINE), .USER_W(USER_W)
    ) dut (
        .clk(clk), .rst(rst),
        .pre_vaild(pre_vaild), .pre_ready(pre_ready),
        .mode(mode), .iData(iData), .iUser(iUser),
        .post_vaild(post_vaild), .post_ready(post_ready),
        .oData(oData), .oUser(oUser), .oErr(oErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        real         val;
        bit          err;
        bit          m;
        logic [7:0]  user;
        int          cin;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          lat_chk = 1'b1;
    bit          rand_pr = 1'b0;
    int          stall_from = -1;
    int          stall_len = 0;
    bit          prev_stall = 1'b0;
    logic signed [WIDTH-1:0] prev_data;
    logic [7:0]  prev_user;
    int          outs_seen = 0;

    task automatic chk(input string tag, input real obs, input real exp, input real tol);
        n_cmp++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_bad++;
            $display("FAIL %s: got %0.3f, want %0.3f (tol %0.1f) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic real model(bit m, int d);
        real x;
        x = d / 65536.0;
        if (m)
            return $ln(x) * 65536.0;
        return 0.5 * $ln((1.0 + x) / (1.0 - x)) * 65536.0;
    endfunction

    function automatic bit dom_err(bit m, int d);
        if (m)
            return (d <= 7209) || (d >= 589824);
        return (d >= 52429) || (d <= -52429);
    endfunction

    function automatic int gen(bit m);
        int r;
        int a;
        r = int'($urandom_range(0, 7));
        if (m) begin
            if (r == 0)
                return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7209))
                                                   : int'($urandom_range(589824, 2000000));
            return int'($urandom_range(7900, 583000));
        end
        a = (r == 0) ? int'($urandom_range(52429, 400000)) : int'($urandom_range(0, 51800));
        return ($urandom_range(0, 1) != 0) ? -a : a;
    endfunction

    task automatic step(input bit pv, input bit m, input int d, input logic [7:0] u, output bit acc);
        exp_t e;
        bit   in_win;
        @(negedge clk);
        pre_vaild = pv;
        mode      = m;
        iData     = d;
        iUser     = u;
        in_win    = (cyc >= stall_from) && (cyc < stall_from + stall_len);
        if (in_win)
            post_ready = 1'b0;
        else if (rand_pr)
            post_ready = ($urandom_range(0, 3) != 0);
        else
            post_ready = 1'b1;
        #1;
        if (prev_stall) begin
            chk("hold_vld", post_vaild, 1, 0);
            chk("hold_data", oData, prev_data, 0);
            chk("hold_user", oUser, prev_user, 0);
        end
        if (in_win) begin
            chk("bp_pre_ready", pre_ready, 0, 0);
            chk("bp_post_vaild", post_vaild, 1, 0);
        end
        chk("pre_ready", pre_ready, (post_vaild && !post_ready) ? 0 : 1, 0);
        if (post_vaild && post_ready) begin
            if (q.size() == 0) begin
                chk("stray_out", post_vaild, 0, 0);
            end else begin
                e = q.pop_front();
                chk("oErr", oErr, e.err, 0);
                chk("oUser", oUser, e.user, 0);
                chk(e.m ? "oData_ln" : "oData_atanh", oData,
                    e.err ? 0.0 : e.val, e.err ? 0.0 : (e.m ? 4.0 : 2.0));
                if (lat_chk)
                    chk("latency", cyc - e.cin, LAT, 0);
                outs_seen++;
            end
        end
        acc = pv && pre_ready;
        if (acc) begin
            e.err  = dom_err(m, d);
            e.val  = e.err ? 0.0 : model(m, d);
            e.m    = m;
            e.user = u;
            e.cin  = cyc;
            q.push_back(e);
        end
        prev_stall = post_vaild && !post_ready;
        prev_data  = oData;
        prev_user  = oUser;
    endtask

    task automatic send(input bit m, input int d, input logic [7:0] u);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, m, d, u, acc);
            tries++;
        end while (!acc && tries < 200);
        if (!acc)
            chk("accept", acc, 1, 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 1'b0, 0, 8'h00, acc);
    endtask

    task automatic drain();
        bit acc;
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 1000) begin
            step(1'b0, 1'b0, 0, 8'h00, acc);
            guard++;
        end
        if (q.size() > 0)
            chk("drain", q.size(), 0, 0);
    endtask

    int pos_set[5] = '{32768, 21845, 16384, 13107, 10923};
    int ln_set[4]  = '{131072, 65536, 32768, 327680};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int base;
        int guard;
        bit m;
        rst        = 1'b1;
        pre_vaild  = 1'b0;
        mode       = 1'b0;
        iData      = '0;
        iUser      = '0;
        post_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_post_vaild", post_vaild, 0, 0);
        chk("rst_oData", oData, 0, 0);
        chk("rst_oUser", oUser, 0, 0);
        chk("rst_oErr", oErr, 0, 0);
        chk("rst_pre_ready", pre_ready, 1, 0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 5; i++) send(1'b0, pos_set[i], 8'(i + 10));
        drain();
        for (int i = 0; i < 5; i++) send(1'b0, -pos_set[i], 8'(i));
        drain();
        for (int i = 0; i < 4; i++) send(1'b1, ln_set[i], 8'(i + 40));
        drain();

        send(1'b1, 65536, 8'd20);
        send(1'b0, 60000, 8'd21);
        send(1'b1, 0, 8'd22);
        send(1'b1, 655360, 8'd23);
        send(1'b0, 16384, 8'd24);
        send(1'b0, 52428, 8'd25);
        send(1'b0, 52429, 8'd26);
        send(1'b0, -52428, 8'd27);
        send(1'b0, -52429, 8'd28);
        send(1'b1, 7209, 8'd29);
        send(1'b1, 7210, 8'd30);
        send(1'b1, 589823, 8'd31);
        send(1'b1, 589824, 8'd32);
        drain();

        lat_chk    = 1'b0;
        base       = outs_seen;
        stall_from = cyc + 22;
        stall_len  = 5;
        for (int i = 0; i < 10; i++) begin
            m = i[0];
            send(m, m ? 65536 + i * 20000 : i * 4000 - 18000, 8'(100 + i));
        end
        drain();
        chk("bp_count", outs_seen - base, 10, 0);
        stall_from = -1;
        stall_len  = 0;

        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b0, 2000 * i, 8'(60 + i));
        guard = 0;
        while (!post_vaild && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("pre_rst_post_vaild", post_vaild, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_post_vaild", post_vaild, 0, 0);
        chk("midrst_oData", oData, 0, 0);
        chk("midrst_oUser", oUser, 0, 0);
        chk("midrst_oErr", oErr, 0, 0);
        chk("midrst_pre_ready", pre_ready, 1, 0);
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        idle(40);
        send(1'b0, 16384, 8'd77);
        drain();

        rand_pr = 1'b1;
        lat_chk = 1'b0;
        for (int i = 0; i < 200; i++) begin
            m = ($urandom_range(0, 1) != 0);
            step(($urandom_range(0, 3) != 0), m, gen(m), 8'($urandom_range(0, 255)), acc);
        end
        drain();
        rand_pr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
